// File: rtl/cellnet_sink_check.sv
// Far-end receiver of the cellnet four-phase req/ack link: acknowledges each word,
// checks generation order against the source's address/data sweep and counts errors.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif

module cellnet_sink_check #(
   parameter int unsigned MIN_ADDR = 1,
   parameter int unsigned MAX_ADDR = 1,
   parameter int unsigned ASZ      = `ADDRESS_SIZE,
   parameter int unsigned DSZ      = `DATA_SIZE,
   parameter int unsigned ACK_DLY  = 0,
   parameter int unsigned CNT_SZ   = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ASZ-1:0]    i_addr,
   input  logic [DSZ-1:0]    i_dat,
   input  logic              i_req,
   output logic              o_ack,
   output logic [CNT_SZ-1:0] o_rcv_cnt,
   output logic [CNT_SZ-1:0] o_err_cnt,
   output logic              o_err,
   output logic [ASZ-1:0]    o_last_addr,
   output logic [DSZ-1:0]    o_last_dat
);

   localparam logic [ASZ-1:0] MIN_A    = ASZ'(MIN_ADDR);
   localparam logic [ASZ-1:0] MAX_A    = ASZ'(MAX_ADDR);
   localparam logic [7:0]     DLY_INIT = 8'(ACK_DLY);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t            state_q, state_d;
   logic [7:0]        dly_q, dly_d;
   logic              ack_q, ack_d;
   logic [CNT_SZ-1:0] rcv_q, rcv_d;
   logic [CNT_SZ-1:0] errc_q, errc_d;
   logic              err_q, err_d;
   logic [ASZ-1:0]    last_addr_q, last_addr_d;
   logic [DSZ-1:0]    last_dat_q, last_dat_d;
   logic              synced_q, synced_d;
   logic [ASZ-1:0]    exp_addr_q, exp_addr_d;
   logic [DSZ-1:0]    exp_dat_q, exp_dat_d;
   logic              word_bad;

   function automatic logic [CNT_SZ-1:0] sat_inc(input logic [CNT_SZ-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Out-of-range and out-of-order collapse into a single error per word.
   assign word_bad = (i_addr < MIN_A) || (i_addr > MAX_A) ||
                     (i_addr != exp_addr_q) || (i_dat != exp_dat_q);

   always_comb begin
      state_d     = state_q;
      dly_d       = dly_q;
      ack_d       = ack_q;
      rcv_d       = rcv_q;
      errc_d      = errc_q;
      err_d       = err_q;
      last_addr_d = last_addr_q;
      last_dat_d  = last_dat_q;
      synced_d    = synced_q;
      exp_addr_d  = exp_addr_q;
      exp_dat_d   = exp_dat_q;
      case (state_q)
         IDLE: begin
            if (i_req) begin
               last_addr_d = i_addr;
               last_dat_d  = i_dat;
               rcv_d       = rcv_q + 1'b1;
               synced_d    = 1'b1;
               if (synced_q && word_bad) begin
                  errc_d = sat_inc(errc_q);
                  err_d  = 1'b1;
               end
               // Expectation always follows the captured word so one bad word resyncs.
               if (i_addr == MAX_A) begin
                  exp_addr_d = MIN_A;
                  exp_dat_d  = i_dat + 1'b1;
               end else begin
                  exp_addr_d = i_addr + 1'b1;
                  exp_dat_d  = i_dat;
               end
               if (ACK_DLY == 0) begin
                  state_d = ACK;
                  ack_d   = 1'b1;
               end else begin
                  state_d = WAIT;
                  dly_d   = DLY_INIT;
               end
            end
         end
         WAIT: begin
            if (!i_req) begin
               errc_d  = sat_inc(errc_q);
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (dly_q == 8'd1) begin
               state_d = ACK;
               ack_d   = 1'b1;
            end else begin
               dly_d = dly_q - 8'd1;
            end
         end
         ACK: begin
            if (!i_req) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            ack_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         dly_q       <= '0;
         ack_q       <= 1'b0;
         rcv_q       <= '0;
         errc_q      <= '0;
         err_q       <= 1'b0;
         last_addr_q <= '0;
         last_dat_q  <= '0;
         synced_q    <= 1'b0;
         exp_addr_q  <= '0;
         exp_dat_q   <= '0;
      end else begin
         state_q     <= state_d;
         dly_q       <= dly_d;
         ack_q       <= ack_d;
         rcv_q       <= rcv_d;
         errc_q      <= errc_d;
         err_q       <= err_d;
         last_addr_q <= last_addr_d;
         last_dat_q  <= last_dat_d;
         synced_q    <= synced_d;
         exp_addr_q  <= exp_addr_d;
         exp_dat_q   <= exp_dat_d;
      end
   end

   assign o_ack       = ack_q;
   assign o_rcv_cnt   = rcv_q;
   assign o_err_cnt   = errc_q;
   assign o_err       = err_q;
   assign o_last_addr = last_addr_q;
   assign o_last_dat  = last_dat_q;

endmodule

// File: tb/tb_cellnet_sink_check.sv
// Scoreboard bench for cellnet_sink_check: unit A (MIN=1,MAX=3,no ack delay,4-bit counters)
// and unit B (MIN=MAX=1, ack delay 3) against a sequence-index reference model.
module tb_cellnet_sink_check;

   typedef struct {
      int rcv;
      int errc;
      int errf;
      int la;
      int ld;
   } exp_t;

   int MINA[2] = '{1, 1};
   int MAXA[2] = '{3, 1};
   int DLY[2]  = '{0, 3};
   int CMAX[2] = '{15, 65535};

   logic        clk;
   logic        rst_a, rst_b;
   logic [3:0]  addr_a, addr_b, dat_a, dat_b;
   logic        req_a, req_b;
   logic        ack_a, ack_b;
   logic [3:0]  rcv_a, errc_a;
   logic [15:0] rcv_b, errc_b;
   logic        err_a, err_b;
   logic [3:0]  la_a, la_b, ld_a, ld_b;

   cellnet_sink_check #(.MIN_ADDR(1), .MAX_ADDR(3), .ASZ(4), .DSZ(4), .ACK_DLY(0), .CNT_SZ(4)) dut_a (
      .i_clk(clk), .i_rst(rst_a), .i_addr(addr_a), .i_dat(dat_a), .i_req(req_a),
      .o_ack(ack_a), .o_rcv_cnt(rcv_a), .o_err_cnt(errc_a), .o_err(err_a),
      .o_last_addr(la_a), .o_last_dat(ld_a));

   cellnet_sink_check #(.MIN_ADDR(1), .MAX_ADDR(1), .ASZ(4), .DSZ(4), .ACK_DLY(3), .CNT_SZ(16)) dut_b (
      .i_clk(clk), .i_rst(rst_b), .i_addr(addr_b), .i_dat(dat_b), .i_req(req_b),
      .o_ack(ack_b), .o_rcv_cnt(rcv_b), .o_err_cnt(errc_b), .o_err(err_b),
      .o_last_addr(la_b), .o_last_dat(ld_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;
   exp_t q0[$];
   exp_t q1[$];

   int m_rcv[2], m_err[2], m_flag[2], m_synced[2], m_ea[2], m_ed[2], m_la[2], m_ld[2];

   task automatic chk(input string nm, input int act, input int req_v);
      checks++;
      if (act != req_v) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req_v, $time);
      end
   endtask

   function automatic void model_reset(input int u);
      m_rcv[u] = 0; m_err[u] = 0; m_flag[u] = 0; m_synced[u] = 0;
      m_ea[u] = 0; m_ed[u] = 0; m_la[u] = 0; m_ld[u] = 0;
   endfunction

   function automatic void model_err(input int u);
      if (m_err[u] < CMAX[u]) m_err[u]++;
      m_flag[u] = 1;
   endfunction

   // Words in range map to a linear sequence index d*N + (a-MIN); the successor is index+1.
   function automatic void model_capture(input int u, input int a, input int d);
      int n, idx;
      n = MAXA[u] - MINA[u] + 1;
      m_rcv[u]++;
      m_la[u] = a;
      m_ld[u] = d;
      if (m_synced[u] != 0 &&
          (a < MINA[u] || a > MAXA[u] || a != m_ea[u] || d != m_ed[u]))
         model_err(u);
      m_synced[u] = 1;
      if (a >= MINA[u] && a <= MAXA[u]) begin
         idx = d * n + (a - MINA[u]) + 1;
         m_ea[u] = MINA[u] + idx % n;
         m_ed[u] = (idx / n) % 16;
      end else begin
         m_ea[u] = (a + 1) % 16;
         m_ed[u] = d;
      end
   endfunction

   function automatic void push_exp(input int u);
      exp_t e;
      e.rcv  = m_rcv[u] % (CMAX[u] + 1);
      e.errc = m_err[u];
      e.errf = m_flag[u];
      e.la   = m_la[u];
      e.ld   = m_ld[u];
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
   endfunction

   function automatic bit ack_of(input int u);
      return (u == 0) ? ack_a : ack_b;
   endfunction

   task automatic drive(input int u, input int a, input int d, input bit r);
      if (u == 0) begin
         addr_a = 4'(a); dat_a = 4'(d); req_a = r;
      end else begin
         addr_b = 4'(a); dat_b = 4'(d); req_b = r;
      end
   endtask

   task automatic send(input int u, input int a, input int d);
      int n;
      bit seen;
      @(negedge clk);
      drive(u, a, d, 1'b1);
      model_capture(u, a, d);
      push_exp(u);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         seen = ack_of(u);
      end
      if (!seen) chk((u == 0) ? "a_ack_timeout" : "b_ack_timeout", 0, 1);
      else chk((u == 0) ? "a_ack_latency" : "b_ack_latency", n, DLY[u] + 1);
      drive(u, a, d, 1'b0);
      n = 0;
      seen = 1'b1;
      while (seen && n < 20) begin
         @(negedge clk);
         n++;
         seen = ack_of(u);
      end
      chk((u == 0) ? "a_ack_fall" : "b_ack_fall", n, 1);
   endtask

   initial begin : mon_a
      exp_t e;
      bit prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_a && !prev) begin
            if (q0.size() == 0) chk("a_unexpected_ack", 1, 0);
            else begin
               e = q0.pop_front();
               chk("a_rcv_cnt", int'(rcv_a), e.rcv);
               chk("a_err_cnt", int'(errc_a), e.errc);
               chk("a_err_flag", int'(err_a), e.errf);
               chk("a_last_addr", int'(la_a), e.la);
               chk("a_last_dat", int'(ld_a), e.ld);
            end
         end
         prev = ack_a;
      end
   end

   initial begin : mon_b
      exp_t e;
      bit prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_b && !prev) begin
            if (q1.size() == 0) chk("b_unexpected_ack", 1, 0);
            else begin
               e = q1.pop_front();
               chk("b_rcv_cnt", int'(rcv_b), e.rcv);
               chk("b_err_cnt", int'(errc_b), e.errc);
               chk("b_err_flag", int'(err_b), e.errf);
               chk("b_last_addr", int'(la_b), e.la);
               chk("b_last_dat", int'(ld_b), e.ld);
            end
         end
         prev = ack_b;
      end
   end

   initial begin : stim
      int a, d, idx, wait_n;
      rst_a = 1'b1; rst_b = 1'b1;
      drive(0, 0, 0, 1'b0);
      drive(1, 0, 0, 1'b0);
      model_reset(0);
      model_reset(1);
      repeat (3) @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      chk("a_rst_ack", int'(ack_a), 0);
      chk("a_rst_rcv", int'(rcv_a), 0);
      chk("a_rst_errc", int'(errc_a), 0);
      chk("a_rst_err", int'(err_a), 0);
      chk("a_rst_last", int'({la_a, ld_a}), 0);
      chk("b_rst_ack", int'(ack_b), 0);
      chk("b_rst_rcv", int'(rcv_b), 0);
      chk("b_rst_errc", int'(errc_b), 0);

      // Unit A: 100-word source sweep starting at (2,0).
      for (int k = 0; k < 100; k++) begin
         idx = k + 1;
         send(0, 1 + idx % 3, (idx / 3) % 16);
      end
      @(negedge clk);
      chk("a_100_rcv", int'(rcv_a), 100 % 16);
      chk("a_100_errc", int'(errc_a), 0);
      chk("a_100_err", int'(err_a), 0);
      chk("a_100_last_addr", int'(la_a), 1 + 100 % 3);
      chk("a_100_last_dat", int'(ld_a), (100 / 3) % 16);

      // Unit A: async reset while ack is high.
      @(negedge clk);
      drive(0, m_ea[0], m_ed[0], 1'b1);
      model_capture(0, m_ea[0], m_ed[0]);
      push_exp(0);
      @(negedge clk);
      chk("a_ack_before_rst", int'(ack_a), 1);
      #2 rst_a = 1'b1;
      #1;
      chk("a_midrst_ack", int'(ack_a), 0);
      chk("a_midrst_rcv", int'(rcv_a), 0);
      chk("a_midrst_errc", int'(errc_a), 0);
      chk("a_midrst_err", int'(err_a), 0);
      chk("a_midrst_last", int'({la_a, ld_a}), 0);
      drive(0, 0, 0, 1'b0);
      @(negedge clk);
      rst_a = 1'b0;
      model_reset(0);

      // Sync word, good word, bad word, then resync.
      send(0, 2, 0);
      send(0, 3, 0);
      send(0, 1, 5);
      @(negedge clk);
      chk("a_bad3_errc", int'(errc_a), 1);
      send(0, 2, 5);
      @(negedge clk);
      chk("a_resync_errc", int'(errc_a), 1);
      chk("a_resync_err", int'(err_a), 1);

      // Unit A: random mix of correct and arbitrary words.
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            a = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 15));
         end else begin
            a = m_ea[0];
            d = m_ed[0];
         end
         send(0, a, d);
      end

      // Unit A: 20 out-of-range words drive the error counter into saturation.
      for (int k = 0; k < 20; k++) send(0, 0, int'($urandom_range(0, 15)));
      @(negedge clk);
      chk("a_sat_errc", int'(errc_a), 15);
      chk("a_wrap_rcv", int'(rcv_a), m_rcv[0] % 16);

      // Unit B: single-address sweep with data wrap 15->0.
      for (int k = 1; k <= 50; k++) send(1, 1, k % 16);
      @(negedge clk);
      chk("b_50_errc", int'(errc_b), 0);
      chk("b_50_last_dat", int'(ld_b), 50 % 16);
      chk("b_50_rcv", int'(rcv_b), 50);

      // Unit B: request withdrawn one cycle after capture.
      @(negedge clk);
      a = m_ea[1];
      d = m_ed[1];
      drive(1, a, d, 1'b1);
      model_capture(1, a, d);
      @(negedge clk);
      chk("b_wait_ack", int'(ack_b), 0);
      drive(1, a, d, 1'b0);
      @(negedge clk);
      model_err(1);
      chk("b_abort_ack", int'(ack_b), 0);
      chk("b_abort_errc", int'(errc_b), m_err[1]);
      chk("b_abort_err", int'(err_b), 1);
      chk("b_abort_rcv", int'(rcv_b), m_rcv[1]);
      repeat (4) @(negedge clk);
      chk("b_abort_no_ack", int'(ack_b), 0);
      send(1, m_ea[1], m_ed[1]);

      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 2) == 0) send(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
         else send(1, m_ea[1], m_ed[1]);
      end

      wait_n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      chk("scoreboard_drained", q0.size() + q1.size(), 0);
      chk("a_final_errc", int'(errc_a), m_err[0]);
      chk("b_final_errc", int'(errc_b), m_err[1]);
      chk("b_final_rcv", int'(rcv_b), m_rcv[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
